// File: rtl/seq_restoring_divider_if.sv
// Bus bundle for seq_restoring_divider: start/busy/done handshake, operands
// and results. The div_by_zero flag exists only when DIV_BY_ZERO_FLAG_EN is
// defined.
//
// Handshake: the master raises start with dividend/divisor stable; the slave
// accepts it on a rising edge where busy=0 and samples the operands on that
// edge only. done is a one-cycle pulse marking quotient/remainder valid. The
// results are held until a later operation completes.
interface seq_restoring_divider_if #(
  parameter int width = 8
);
  logic                 start;
  logic [2*width-1:0]   dividend;
  logic [width-1:0]     divisor;
  logic                 busy;
  logic                 done;
  logic [2*width-1:0]   quotient;
  logic [width-1:0]     remainder;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic                 div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2*width-bit dividend / width-bit divisor.
// It produces one quotient bit per clock, so an operation takes 2*width
// RUN cycles followed by a one-cycle DONE pulse.
// Optional feature macro: DIV_BY_ZERO_FLAG_EN. When it is defined, a zero
// divisor skips RUN and raises div_by_zero. The results match the
// iterative path either way.
module seq_restoring_divider #(
  parameter int width = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus,
  output logic [1:0]              dbg_state
);

  localparam int DW = 2 * width;
  localparam int CW = $clog2(DW);
  localparam logic [CW-1:0] LAST_CNT = CW'(DW - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [width:0]      rem_q, rem_d;       // partial remainder R
  logic [DW-1:0]       sh_q, sh_d;         // dividend bits out, quotient bits in
  logic [width-1:0]    dsr_q, dsr_d;       // latched divisor
  logic [DW-1:0]       quot_q, quot_d;
  logic [width-1:0]    remo_q, remo_d;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic                dbz_q, dbz_d;
`endif

  // Datapath for one restoring step
  logic [width:0]      r_shift;
  logic [width:0]      r_next;
  logic                q_bit;
  logic [DW-1:0]       sh_next;

  // One iteration: shift in the next dividend MSB, then subtract the divisor if it fits
  always_comb begin
    r_shift = {rem_q[width-1:0], sh_q[DW-1]};
    q_bit   = (r_shift >= {1'b0, dsr_q});
    r_next  = q_bit ? (r_shift - {1'b0, dsr_q}) : r_shift;
    sh_next = {sh_q[DW-2:0], q_bit};
  end

  // Next-state and register-update logic; everything holds unless stated
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    sh_d    = sh_q;
    dsr_d   = dsr_q;
    quot_d  = quot_q;
    remo_d  = remo_q;
`ifdef DIV_BY_ZERO_FLAG_EN
    dbz_d   = dbz_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          // A start in DONE is accepted as well. done still pulses this cycle
          // for the operation that just finished.
          state_d = S_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          sh_d    = bus.dividend;
          dsr_d   = bus.divisor;
`ifdef DIV_BY_ZERO_FLAG_EN
          dbz_d   = 1'b0;
          if (bus.divisor == '0) begin
            // These are the same results the full iteration would give.
            state_d = S_DONE;
            quot_d  = '1;
            remo_d  = bus.dividend[width-1:0];
            dbz_d   = 1'b1;
          end
`endif
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        rem_d = r_next;
        sh_d  = sh_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_CNT) begin
          // Results are published only on the edge that enters DONE.
          state_d = S_DONE;
          quot_d  = sh_next;
          remo_d  = r_next[width-1:0];
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      sh_q    <= '0;
      dsr_q   <= '0;
      quot_q  <= '0;
      remo_q  <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      sh_q    <= sh_d;
      dsr_q   <= dsr_d;
      quot_q  <= quot_d;
      remo_q  <= remo_d;
`ifdef DIV_BY_ZERO_FLAG_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  // Outputs decode directly from registered state and results
  always_comb begin
    bus.busy        = (state_q == S_RUN);
    bus.done        = (state_q == S_DONE);
    bus.quotient    = quot_q;
    bus.remainder   = remo_q;
`ifdef DIV_BY_ZERO_FLAG_EN
    bus.div_by_zero = dbz_q;
`endif
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider (width=8). The bench drives and
// samples on the falling edge. Expected values are computed by hand.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic clk;
  logic rst;
  logic [1:0] dbg_state;

  int total;
  int bad;

  seq_restoring_divider_if #(.width(W)) bus ();

  seq_restoring_divider #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it does not match
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a start at the current falling edge; it is accepted on the next rising edge
  task automatic drive_start(input logic [2*W-1:0] dvd, input logic [W-1:0] dsr);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dsr;
  endtask

  // Count rising edges from acceptance until done is high (0 = timeout)
  task automatic wait_done(output int lat, output int busy_n);
    lat    = 0;
    busy_n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
  endtask

  int lat;
  int busy_n;
  int done_n;

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_quot", {16'd0, bus.quotient}, 32'd0);
    check("rst_rem",  {24'd0, bus.remainder}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // 1: 150/10, latency and busy length
    drive_start(16'd150, 8'd10);
    wait_done(lat, busy_n);
    check("t1_lat",  lat, 32'd17);
    check("t1_busy", busy_n, 32'd16);
    check("t1_quot", {16'd0, bus.quotient}, 32'd15);
    check("t1_rem",  {24'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    check("t1_done_pulse", {31'd0, bus.done}, 32'd0);

    // 2: 65025/255, then 300/7
    drive_start(16'd65025, 8'd255);
    wait_done(lat, busy_n);
    check("t2a_lat",  lat, 32'd17);
    check("t2a_quot", {16'd0, bus.quotient}, 32'd255);
    check("t2a_rem",  {24'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    drive_start(16'd300, 8'd7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("t2b_hold_quot", {16'd0, bus.quotient}, 32'd255);
    for (int i = 0; i < 30 && !bus.done; i++) @(negedge clk);
    check("t2b_done", {31'd0, bus.done}, 32'd1);
    check("t2b_quot", {16'd0, bus.quotient}, 32'd42);
    check("t2b_rem",  {24'd0, bus.remainder}, 32'd6);
    @(negedge clk);

    // 3: 0/123, then 65535/1
    drive_start(16'd0, 8'd123);
    wait_done(lat, busy_n);
    check("t3a_lat",  lat, 32'd17);
    check("t3a_quot", {16'd0, bus.quotient}, 32'd0);
    check("t3a_rem",  {24'd0, bus.remainder}, 32'd0);
    @(negedge clk);
    drive_start(16'd65535, 8'd1);
    wait_done(lat, busy_n);
    check("t3b_lat",  lat, 32'd17);
    check("t3b_quot", {16'd0, bus.quotient}, 32'd65535);
    check("t3b_rem",  {24'd0, bus.remainder}, 32'd0);
    @(negedge clk);

    // 4a: start while busy is ignored
    drive_start(16'd300, 8'd7);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    drive_start(16'd1000, 8'd40);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) begin
        done_n++;
        check("t4a_quot", {16'd0, bus.quotient}, 32'd42);
        check("t4a_rem",  {24'd0, bus.remainder}, 32'd6);
      end
      @(negedge clk);
    end
    check("t4a_done_count", done_n, 32'd1);

    // 4b: back-to-back start in the done cycle
    drive_start(16'd150, 8'd10);
    wait_done(lat, busy_n);
    check("t4b_first_lat", lat, 32'd17);
    drive_start(16'd65025, 8'd255);
    @(negedge clk);
    bus.start = 1'b0;
    check("t4b_accepted_busy", {31'd0, bus.busy}, 32'd1);
    check("t4b_hold_quot", {16'd0, bus.quotient}, 32'd15);
    lat = 1;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      @(negedge clk);
      lat++;
    end
    check("t4b_second_lat",  lat, 32'd17);
    check("t4b_second_quot", {16'd0, bus.quotient}, 32'd255);
    @(negedge clk);

    // 5: reset 5 cycles into 150/10 aborts it
    drive_start(16'd150, 8'd10);
    repeat (5) @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t5_busy", {31'd0, bus.busy}, 32'd0);
    check("t5_done", {31'd0, bus.done}, 32'd0);
    check("t5_quot", {16'd0, bus.quotient}, 32'd0);
    check("t5_rem",  {24'd0, bus.remainder}, 32'd0);
    rst = 1'b0;
    done_n = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("t5_no_done", done_n, 32'd0);
    drive_start(16'd150, 8'd10);
    wait_done(lat, busy_n);
    check("t5_fresh_lat",  lat, 32'd17);
    check("t5_fresh_quot", {16'd0, bus.quotient}, 32'd15);
    @(negedge clk);

    // 6: 1234/0
    drive_start(16'd1234, 8'd0);
    wait_done(lat, busy_n);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("t6_lat", lat, 32'd1);
    check("t6_dbz", {31'd0, bus.div_by_zero}, 32'd1);
`else
    check("t6_lat", lat, 32'd17);
`endif
    check("t6_quot", {16'd0, bus.quotient}, 32'h0000FFFF);
    check("t6_rem",  {24'd0, bus.remainder}, 32'h000000D2);
    @(negedge clk);
`ifdef DIV_BY_ZERO_FLAG_EN
    check("t6_dbz_hold", {31'd0, bus.div_by_zero}, 32'd1);
    drive_start(16'd300, 8'd7);
    @(negedge clk);
    bus.start = 1'b0;
    check("t6_dbz_clear", {31'd0, bus.div_by_zero}, 32'd0);
    for (int i = 0; i < 30 && !bus.done; i++) @(negedge clk);
    check("t6_after_quot", {16'd0, bus.quotient}, 32'd42);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
